// File: rtl/ddr5_cmd_timer.sv
// DDR5 command spacing timer: accepts decoded commands, enforces command-to-command gaps, issues one cycle later.
// Optional per-command issue counters are compiled in when DDR5_CMD_TIMER_STATS_EN is defined.
module ddr5_cmd_timer #(
    parameter int T_RR  = 4,
    parameter int T_RTW = 5,
    parameter int T_WTR = 6,
    parameter int T_WW  = 4,
    parameter int T_RFC = 16,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] in_cmd,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] out_cmd,
    output logic       busy
`ifdef DDR5_CMD_TIMER_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [15:0] ref_count
`endif
);

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_REF = 2'b11;

    localparam logic [CNT_W-1:0] G_RR  = CNT_W'(T_RR);
    localparam logic [CNT_W-1:0] G_RTW = CNT_W'(T_RTW);
    localparam logic [CNT_W-1:0] G_WTR = CNT_W'(T_WTR);
    localparam logic [CNT_W-1:0] G_WW  = CNT_W'(T_WW);
    localparam logic [CNT_W-1:0] G_RFC = CNT_W'(T_RFC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Once elapsed reaches the larger of the two gaps out of READ/WRITE, no pending constraint remains.
    localparam logic [CNT_W-1:0] G_RD_MAX = (T_RR > T_RTW) ? G_RR : G_RTW;
    localparam logic [CNT_W-1:0] G_WR_MAX = (T_WTR > T_WW) ? G_WTR : G_WW;

    typedef enum logic [1:0] {
        ST_FREE,
        ST_SPACING,
        ST_REFRESH
    } state_t;

    logic [1:0]       last_cmd_q, last_cmd_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_cmd_q, out_cmd_d;
    logic [CNT_W-1:0] gap;
    logic             accept;
    logic             issue;
    state_t           state;

    always_comb begin
        gap = '0;
        if (last_cmd_q == CMD_REF) begin
            gap = G_RFC;
        end else if (in_cmd != CMD_NOP) begin
            case (last_cmd_q)
                CMD_RD:  gap = (in_cmd == CMD_RD) ? G_RR : G_RTW;
                CMD_WR:  gap = (in_cmd == CMD_WR) ? G_WW : G_WTR;
                default: gap = '0;
            endcase
        end
    end

    assign in_ready = (elapsed_q >= gap);
    assign accept   = in_valid & in_ready;
    assign issue    = accept & (in_cmd != CMD_NOP);

    always_comb begin
        state = ST_FREE;
        case (last_cmd_q)
            CMD_REF: state = (elapsed_q < G_RFC) ? ST_REFRESH : ST_FREE;
            CMD_RD:  state = (elapsed_q < G_RD_MAX) ? ST_SPACING : ST_FREE;
            CMD_WR:  state = (elapsed_q < G_WR_MAX) ? ST_SPACING : ST_FREE;
            default: state = ST_FREE;
        endcase
    end

    assign busy = (state == ST_REFRESH);

    always_comb begin
        last_cmd_d  = last_cmd_q;
        elapsed_d   = elapsed_q;
        out_valid_d = issue;
        out_cmd_d   = out_cmd_q;
        if (issue) begin
            last_cmd_d = in_cmd;
            out_cmd_d  = in_cmd;
            elapsed_d  = CNT_W'(1);
        end else if (!accept && (elapsed_q != CNT_MAX)) begin
            // An accepted NOP freezes the counter; otherwise it counts up and saturates.
            elapsed_d = elapsed_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_cmd_q  <= CMD_NOP;
            elapsed_q   <= CNT_MAX;
            out_valid_q <= 1'b0;
            out_cmd_q   <= CMD_NOP;
        end else begin
            last_cmd_q  <= last_cmd_d;
            elapsed_q   <= elapsed_d;
            out_valid_q <= out_valid_d;
            out_cmd_q   <= out_cmd_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_cmd   = out_cmd_q;

`ifdef DDR5_CMD_TIMER_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] ref_count_q, ref_count_d;

    always_comb begin
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        ref_count_d = ref_count_q;
        if (out_valid_q) begin
            case (out_cmd_q)
                CMD_RD:  rd_count_d  = rd_count_q + 16'd1;
                CMD_WR:  wr_count_d  = wr_count_q + 16'd1;
                CMD_REF: ref_count_d = ref_count_q + 16'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            ref_count_q <= '0;
        end else begin
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            ref_count_q <= ref_count_d;
        end
    end

    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign ref_count = ref_count_q;
`endif

endmodule

// File: tb/tb_ddr5_cmd_timer.sv
// Directed bench for ddr5_cmd_timer with default timing parameters (T_RR=4, T_RTW=5, T_WTR=6, T_WW=4, T_RFC=16).
module tb_ddr5_cmd_timer;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] RD  = 2'b01;
    localparam logic [1:0] WR  = 2'b10;
    localparam logic [1:0] REF = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_cmd;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_cmd;
    logic       busy;
`ifdef DDR5_CMD_TIMER_STATS_EN
    logic [15:0] rd_count, wr_count, ref_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    ddr5_cmd_timer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_cmd    (in_cmd),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_cmd   (out_cmd),
        .busy      (busy)
`ifdef DDR5_CMD_TIMER_STATS_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .ref_count (ref_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_cmd   = NOP;
        step();
        step();
        rst = 1'b0;
    endtask

    // Offer cmd at cycle 0, expect it taken on that edge; returns at cycle 1.
    task automatic issue0(input logic [1:0] cmd);
        in_valid = 1'b1;
        in_cmd   = cmd;
        #1;
        check("issue0_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        check("issue0_out_valid", {31'd0, out_valid}, 32'd1);
        check("issue0_out_cmd", {30'd0, out_cmd}, {30'd0, cmd});
    endtask

    // Hold cmd valid from cycle 'start'; acc is the cycle it was accepted (-1 on timeout).
    task automatic hold_until_accept(input logic [1:0] cmd, input int start, output int acc);
        bit done;
        done = 1'b0;
        acc  = -1;
        in_valid = 1'b1;
        in_cmd   = cmd;
        for (int c = start; c < start + 40 && !done; c++) begin
            #1;
            if (in_ready) begin
                acc  = c;
                done = 1'b1;
            end
            step();
        end
        in_valid = 1'b0;
        #1;
        if (!done) begin
            check("accept_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        int acc;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_cmd   = NOP;

        // Reset state
        do_reset();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_cmd", {30'd0, out_cmd}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            in_cmd = 2'(k);
            #1;
            check($sformatf("rst_ready_cmd%0d", k), {31'd0, in_ready}, 32'd1);
        end
        in_cmd = NOP;

        // Reset then READ, then READ held: accepted at 4, issued at 5
        issue0(RD);
        hold_until_accept(RD, 1, acc);
        check("rd_rd_accept_cycle", acc, 32'd4);
        check("rd_rd_out_valid", {31'd0, out_valid}, 32'd1);
        check("rd_rd_out_cmd", {30'd0, out_cmd}, {30'd0, RD});
        step();
        check("rd_rd_pulse_one_cycle", {31'd0, out_valid}, 32'd0);

        // READ -> WRITE uses T_RTW
        do_reset();
        issue0(RD);
        hold_until_accept(WR, 1, acc);
        check("rd_wr_accept_cycle", acc, 32'd5);
        check("rd_wr_out_cmd", {30'd0, out_cmd}, {30'd0, WR});

        // WRITE -> READ uses T_WTR
        do_reset();
        issue0(WR);
        hold_until_accept(RD, 1, acc);
        check("wr_rd_accept_cycle", acc, 32'd6);

        // WRITE -> WRITE uses T_WW
        do_reset();
        issue0(WR);
        hold_until_accept(WR, 1, acc);
        check("wr_wr_accept_cycle", acc, 32'd4);

        // REFRESH window: NOP then READ offered, nothing accepted until cycle 16
        do_reset();
        issue0(REF);
        for (int c = 1; c < 16; c++) begin
            in_valid = 1'b1;
            in_cmd   = (c < 8) ? NOP : RD;
            #1;
            check($sformatf("ref_busy_c%0d", c), {31'd0, busy}, 32'd1);
            check($sformatf("ref_ready_c%0d", c), {31'd0, in_ready}, 32'd0);
            if (c > 1) check($sformatf("ref_no_issue_c%0d", c), {31'd0, out_valid}, 32'd0);
            step();
        end
        in_cmd = RD;
        #1;
        check("ref_busy_c16", {31'd0, busy}, 32'd0);
        check("ref_ready_c16", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("ref_rd_out_valid", {31'd0, out_valid}, 32'd1);
        check("ref_rd_out_cmd", {30'd0, out_cmd}, {30'd0, RD});

        // Cycle 17: accepted NOP is not issued and freezes elapsed (stays 1 at cycle 18)
        in_valid = 1'b1;
        in_cmd   = NOP;
        #1;
        check("nop_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("nop_no_issue", {31'd0, out_valid}, 32'd0);
        hold_until_accept(RD, 18, acc);
        check("nop_freeze_rd_accept", acc, 32'd21);

        // Reset during REFRESH window
        do_reset();
        issue0(REF);
        for (int c = 1; c < 5; c++) step();
        check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy_after", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        in_valid = 1'b1;
        in_cmd   = RD;
        #1;
        check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("rst_mid_rd_issue", {31'd0, out_valid}, 32'd1);

        // Reset drops a pending issue pulse
        do_reset();
        issue0(WR);
        rst = 1'b1;
        #1;
        check("rst_drop_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_drop_out_cmd", {30'd0, out_cmd}, 32'd0);
        rst = 1'b0;

`ifdef DDR5_CMD_TIMER_STATS_EN
        do_reset();
        check("stats_rst_rd", {16'd0, rd_count}, 32'd0);
        issue0(RD);
        hold_until_accept(RD, 1, acc);
        hold_until_accept(RD, 0, acc);
        hold_until_accept(WR, 0, acc);
        hold_until_accept(WR, 0, acc);
        hold_until_accept(REF, 0, acc);
        step();
        check("stats_rd", {16'd0, rd_count}, 32'd3);
        check("stats_wr", {16'd0, wr_count}, 32'd2);
        check("stats_ref", {16'd0, ref_count}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
